// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared widths, constants and types for the renaming register file
package reg_file_rename_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_ID_W  = 4;
  localparam int ROB_SIZE  = 1 << ROB_ID_W;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [ROB_ID_W-1:0]  rob_id_t;

  localparam reg_idx_t ZERO_REG = '0;

  typedef struct packed {
    data_t   value;
    logic    busy;
    rob_id_t tag;
  } read_resp_t;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_file_rename_if.sv
// rtl/reg_file_rename_if.sv - issue, operand-read and commit bundle between decoder/ROB and register file
interface reg_file_rename_if;
  import reg_file_rename_pkg::*;

  logic     ID_issue_valid;
  reg_idx_t ID_rd;
  rob_id_t  ID_rob_id;
  reg_idx_t ID_rs1;
  reg_idx_t ID_rs2;

  data_t    rs1_value;
  logic     rs1_busy;
  rob_id_t  rs1_tag;
  data_t    rs2_value;
  logic     rs2_busy;
  rob_id_t  rs2_tag;

  logic     ROB_commit_valid;
  reg_idx_t ROB_commit_rd;
  data_t    ROB_commit_value;
  rob_id_t  ROB_commit_rob_id;

  modport master (
    output ID_issue_valid, ID_rd, ID_rob_id, ID_rs1, ID_rs2,
    output ROB_commit_valid, ROB_commit_rd, ROB_commit_value, ROB_commit_rob_id,
    input  rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag
  );

  modport slave (
    input  ID_issue_valid, ID_rd, ID_rob_id, ID_rs1, ID_rs2,
    input  ROB_commit_valid, ROB_commit_rd, ROB_commit_value, ROB_commit_rob_id,
    output rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag
  );

endinterface

// File: rtl/reg_file_rename_rf_read_port.sv
// rtl/reg_file_rename_rf_read_port.sv - one operand read port: x0 masking and optional commit forwarding
// Forwarding is compiled in with RF_COMMIT_BYPASS_EN.
module rf_read_port
  import reg_file_rename_pkg::*;
(
  input  reg_idx_t   rs_i,
  input  data_t      reg_value_i,
  input  logic       reg_busy_i,
  input  rob_id_t    reg_tag_i,
  input  logic       commit_valid_i,
  input  reg_idx_t   commit_rd_i,
  input  data_t      commit_value_i,
  input  rob_id_t    commit_rob_id_i,
  output read_resp_t resp_o
);

`ifdef RF_COMMIT_BYPASS_EN
  logic fwd_hit;
  // Only the commit that would actually clear busy may be forwarded; a stale one must not.
  assign fwd_hit = commit_valid_i && (commit_rd_i == rs_i) && reg_busy_i
                   && (reg_tag_i == commit_rob_id_i);
`else
  logic fwd_hit;
  logic unused_commit;
  assign fwd_hit       = FALSE;
  assign unused_commit = ^{commit_valid_i, commit_rd_i, commit_value_i, commit_rob_id_i};
`endif

  always_comb begin
    resp_o = '0;
    if (!is_zero_reg(rs_i)) begin
      if (fwd_hit) begin
        resp_o.value = commit_value_i;
        resp_o.busy  = FALSE;
        resp_o.tag   = reg_tag_i;
      end else begin
        resp_o.value = reg_value_i;
        resp_o.busy  = reg_busy_i;
        resp_o.tag   = reg_tag_i;
      end
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
// Optional macro RF_COMMIT_BYPASS_EN forwards the same-cycle commit onto the read ports.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  reg_file_rename_if.slave rf
);

  data_t              regs_q [REG_NUM];
  data_t              regs_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  rob_id_t            tag_q  [REG_NUM];
  rob_id_t            tag_d  [REG_NUM];

  logic commit_en;
  logic issue_en;

  assign commit_en = rdy && rf.ROB_commit_valid && !is_zero_reg(rf.ROB_commit_rd);
  assign issue_en  = rdy && !flush && rf.ID_issue_valid && !is_zero_reg(rf.ID_rd);

  // Commit is applied first so that a same-cycle issue to the same rd overrides busy/tag.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_en) begin
      regs_d[rf.ROB_commit_rd] = rf.ROB_commit_value;
      if (busy_q[rf.ROB_commit_rd] && (tag_q[rf.ROB_commit_rd] == rf.ROB_commit_rob_id)) begin
        busy_d[rf.ROB_commit_rd] = FALSE;
      end
    end
    if (rdy && flush) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_en) begin
      busy_d[rf.ID_rd] = TRUE;
      tag_d[rf.ID_rd]  = rf.ID_rob_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  read_resp_t rs1_resp;
  read_resp_t rs2_resp;

  rf_read_port u_rd1 (
    .rs_i            (rf.ID_rs1),
    .reg_value_i     (regs_q[rf.ID_rs1]),
    .reg_busy_i      (busy_q[rf.ID_rs1]),
    .reg_tag_i       (tag_q[rf.ID_rs1]),
    .commit_valid_i  (rf.ROB_commit_valid),
    .commit_rd_i     (rf.ROB_commit_rd),
    .commit_value_i  (rf.ROB_commit_value),
    .commit_rob_id_i (rf.ROB_commit_rob_id),
    .resp_o          (rs1_resp)
  );

  rf_read_port u_rd2 (
    .rs_i            (rf.ID_rs2),
    .reg_value_i     (regs_q[rf.ID_rs2]),
    .reg_busy_i      (busy_q[rf.ID_rs2]),
    .reg_tag_i       (tag_q[rf.ID_rs2]),
    .commit_valid_i  (rf.ROB_commit_valid),
    .commit_rd_i     (rf.ROB_commit_rd),
    .commit_value_i  (rf.ROB_commit_value),
    .commit_rob_id_i (rf.ROB_commit_rob_id),
    .resp_o          (rs2_resp)
  );

  assign rf.rs1_value = rs1_resp.value;
  assign rf.rs1_busy  = rs1_resp.busy;
  assign rf.rs1_tag   = rs1_resp.tag;
  assign rf.rs2_value = rs2_resp.value;
  assign rf.rs2_busy  = rs2_resp.busy;
  assign rf.rs2_tag   = rs2_resp.tag;

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - directed bench for reg_file_rename
module tb_reg_file_rename;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;
  int   total;
  int   bad;

  reg_file_rename_if rf_if ();

  reg_file_rename dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.ID_issue_valid   = 1'b0;
    rf_if.ID_rd            = '0;
    rf_if.ID_rob_id        = '0;
    rf_if.ROB_commit_valid = 1'b0;
    rf_if.ROB_commit_rd    = '0;
    rf_if.ROB_commit_value = '0;
    rf_if.ROB_commit_rob_id = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] rob);
    rf_if.ID_issue_valid = 1'b1;
    rf_if.ID_rd          = rd;
    rf_if.ID_rob_id      = rob;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] val);
    rf_if.ROB_commit_valid  = 1'b1;
    rf_if.ROB_commit_rd     = rd;
    rf_if.ROB_commit_rob_id = rob;
    rf_if.ROB_commit_value  = val;
  endtask

  task automatic rd_ports(input logic [4:0] a, input logic [4:0] b);
    rf_if.ID_rs1 = a;
    rf_if.ID_rs2 = b;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    idle();
    rf_if.ID_rs1 = '0;
    rf_if.ID_rs2 = '0;
    tick();
    rst = 1'b0;

    rd_ports(5'd5, 5'd31);
    chk("rst_rs1_value", rf_if.rs1_value, 32'h0);
    chk("rst_rs1_busy",  rf_if.rs1_busy, 0);
    chk("rst_rs2_value", rf_if.rs2_value, 32'h0);
    chk("rst_rs2_busy",  rf_if.rs2_busy, 0);
    chk("rst_rs2_tag",   rf_if.rs2_tag, 0);

    issue(5'd3, 4'd7);
    rd_ports(5'd3, 5'd0);
    chk("issue_same_cycle_old_map", rf_if.rs1_busy, 0);
    tick(); idle();
    rd_ports(5'd3, 5'd0);
    chk("issue_busy", rf_if.rs1_busy, 1);
    chk("issue_tag",  rf_if.rs1_tag, 7);

    commit(5'd3, 4'd7, 32'hDEADBEEF);
    rd_ports(5'd3, 5'd0);
`ifdef RF_COMMIT_BYPASS_EN
    chk("commit3_same_cycle_busy", rf_if.rs1_busy, 0);
    chk("commit3_same_cycle_value", rf_if.rs1_value, 32'hDEADBEEF);
`else
    chk("commit3_same_cycle_busy", rf_if.rs1_busy, 1);
`endif
    tick(); idle();
    rd_ports(5'd3, 5'd0);
    chk("commit3_busy",  rf_if.rs1_busy, 0);
    chk("commit3_value", rf_if.rs1_value, 32'hDEADBEEF);

    issue(5'd4, 4'd2); tick();
    issue(5'd4, 4'd5); tick(); idle();
    commit(5'd4, 4'd2, 32'h11); tick(); idle();
    rd_ports(5'd4, 5'd0);
    chk("stale_busy",  rf_if.rs1_busy, 1);
    chk("stale_tag",   rf_if.rs1_tag, 5);
    chk("stale_value", rf_if.rs1_value, 32'h11);
    commit(5'd4, 4'd5, 32'h22); tick(); idle();
    rd_ports(5'd4, 5'd0);
    chk("newer_busy",  rf_if.rs1_busy, 0);
    chk("newer_value", rf_if.rs1_value, 32'h22);

    issue(5'd6, 4'd1); tick(); idle();
    issue(5'd6, 4'd9);
    commit(5'd6, 4'd1, 32'h33);
    tick(); idle();
    rd_ports(5'd0, 5'd6);
    chk("same_rd_value", rf_if.rs2_value, 32'h33);
    chk("same_rd_busy",  rf_if.rs2_busy, 1);
    chk("same_rd_tag",   rf_if.rs2_tag, 9);

    rdy = 1'b0;
    issue(5'd7, 4'd3);
    commit(5'd3, 4'd0, 32'h99);
    tick(); idle();
    rdy = 1'b1;
    rd_ports(5'd7, 5'd3);
    chk("hold_no_issue",  rf_if.rs1_busy, 0);
    chk("hold_no_commit", rf_if.rs2_value, 32'hDEADBEEF);

    issue(5'd1, 4'd0); tick();
    issue(5'd2, 4'd1); tick();
    issue(5'd3, 4'd2); tick(); idle();
    rd_ports(5'd1, 5'd2);
    chk("pre_flush_busy1", rf_if.rs1_busy, 1);
    chk("pre_flush_tag2",  rf_if.rs2_tag, 1);
    flush = 1'b1;
    issue(5'd8, 4'd3);
    commit(5'd5, 4'd9, 32'h44);
    tick(); idle();
    flush = 1'b0;
    rd_ports(5'd3, 5'd8);
    chk("flush_busy3", rf_if.rs1_busy, 0);
    chk("flush_busy8", rf_if.rs2_busy, 0);
    rd_ports(5'd6, 5'd5);
    chk("flush_busy6",       rf_if.rs1_busy, 0);
    chk("flush_commit_value", rf_if.rs2_value, 32'h44);

    issue(5'd0, 4'd5);
    commit(5'd0, 4'd5, 32'h77);
    tick(); idle();
    rd_ports(5'd0, 5'd0);
    chk("x0_value", rf_if.rs1_value, 32'h0);
    chk("x0_busy",  rf_if.rs1_busy, 0);
    chk("x0_tag",   rf_if.rs2_tag, 0);

    issue(5'd10, 4'd4); tick(); idle();
    commit(5'd10, 4'd3, 32'h66);
    rd_ports(5'd0, 5'd10);
    chk("bypass_stale_busy", rf_if.rs2_busy, 1);
    tick(); idle();
    commit(5'd10, 4'd4, 32'h55);
    rd_ports(5'd0, 5'd10);
`ifdef RF_COMMIT_BYPASS_EN
    chk("bypass_busy",  rf_if.rs2_busy, 0);
    chk("bypass_value", rf_if.rs2_value, 32'h55);
`else
    chk("bypass_busy",  rf_if.rs2_busy, 1);
    chk("bypass_value", rf_if.rs2_value, 32'h66);
`endif
    tick(); idle();
    rd_ports(5'd0, 5'd10);
    chk("after_commit10_busy",  rf_if.rs2_busy, 0);
    chk("after_commit10_value", rf_if.rs2_value, 32'h55);

    issue(5'd12, 4'd6); tick(); idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_ports(5'd3, 5'd12);
    chk("rerst_value3", rf_if.rs1_value, 32'h0);
    chk("rerst_busy12", rf_if.rs2_busy, 0);
    chk("rerst_tag12",  rf_if.rs2_tag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
